// File: rtl/chain_pred_issuer.sv
// chain_pred_issuer: anchor-chaining front end. Keeps a ring of recent anchors,
// issues (anchor, predecessor) pairs to a pipelined score unit nearest-first,
// tracks each pair with a tag delay line and folds returned scores into f(i).
module chain_pred_issuer #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned SCORE_LAT = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chain_clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_rx,
  input  logic [31:0] in_qy,
  input  logic [31:0] in_w,
  input  logic [31:0] cfg_w_avg,
  output logic [31:0] sc_riX,
  output logic [31:0] sc_riY,
  output logic [31:0] sc_qiX,
  output logic [31:0] sc_qiY,
  output logic [31:0] sc_W,
  output logic [31:0] sc_W_avg,
  input  logic [31:0] sc_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_score,
  output logic [31:0] out_pred,
  output logic [31:0] out_idx
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_EMIT} state_t;

  typedef struct packed {
    logic        live;
    logic        ok;
    logic [31:0] j;
    logic [31:0] f;
  } tag_t;

  state_t r_state, w_state_nx;

  logic [31:0] r_rx [DEPTH];
  logic [31:0] r_qy [DEPTH];
  logic [31:0] r_f  [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [31:0]   r_n_stored, r_seq, r_cnt, r_j;
  logic [31:0]   r_ai_rx, r_ai_qy, r_ai_w;
  logic [31:0]   r_best, r_best_pred, r_idx;
  logic [31:0]   r_sc_rix, r_sc_riy, r_sc_qix, r_sc_qiy, r_sc_w, r_sc_wavg;
  logic          r_cur_ok;
  logic [31:0]   r_cur_j, r_cur_f;
  tag_t          r_dly [SCORE_LAT];

  logic          w_accept, w_load_first, w_load_next, w_load, w_ok, w_drained, w_take;
  logic [31:0]   w_jsel, w_a_rx, w_a_qy, w_a_w, w_cand;
  logic [AW-1:0] w_rd_addr;
  tag_t          w_exit;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_EMIT);
  assign out_score = r_best;
  assign out_pred  = r_best_pred;
  assign out_idx   = r_idx;
  assign sc_riX    = r_sc_rix;
  assign sc_riY    = r_sc_riy;
  assign sc_qiX    = r_sc_qix;
  assign sc_qiY    = r_sc_qiy;
  assign sc_W      = r_sc_w;
  assign sc_W_avg  = r_sc_wavg;

  // Pair selection: sc_* registers load one edge ahead so each pair is visible
  // during its issue cycle; the first pair loads on the accept edge itself.
  always_comb begin
    w_accept     = in_valid && (r_state == S_IDLE);
    w_load_first = w_accept && (r_n_stored != '0);
    w_load_next  = (r_state == S_ISSUE) && (r_cnt > 32'd1);
    w_load       = w_load_first || w_load_next;
    w_jsel       = w_load_first ? (r_seq - 32'd1) : (r_j - 32'd1);
    w_a_rx       = w_load_first ? in_rx : r_ai_rx;
    w_a_qy       = w_load_first ? in_qy : r_ai_qy;
    w_a_w        = w_load_first ? in_w  : r_ai_w;
    w_rd_addr    = w_jsel[AW-1:0];
    w_ok         = (r_rx[w_rd_addr] < w_a_rx) && (r_qy[w_rd_addr] < w_a_qy);
  end

  // Fold of the tag leaving the delay line against the returned score.
  always_comb begin
    w_exit = r_dly[SCORE_LAT-1];
    w_cand = w_exit.f + sc_result;
    w_take = w_exit.live && w_exit.ok && ($signed(w_cand) > $signed(r_best));
  end

  // Drained when nothing remains behind the stage that exits this cycle.
  always_comb begin
    w_drained = 1'b1;
    for (int unsigned k = 0; k + 1 < SCORE_LAT; k++) begin
      if (r_dly[k].live) w_drained = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nx = (r_n_stored != '0) ? S_ISSUE : S_EMIT;
      S_ISSUE: if (r_cnt <= 32'd1) w_state_nx = S_DRAIN;
      S_DRAIN: if (w_drained) w_state_nx = S_EMIT;
      S_EMIT:  if (out_ready) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Tag delay line; a stage is live when its pair was visible during ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < SCORE_LAT; k++) r_dly[k] <= '0;
    end else begin
      r_dly[0] <= tag_t'{live: (r_state == S_ISSUE), ok: r_cur_ok, j: r_cur_j, f: r_cur_f};
      for (int unsigned k = 1; k < SCORE_LAT; k++) r_dly[k] <= r_dly[k-1];
    end
  end

  // Ring storage written on the output handshake; contents need no reset.
  always_ff @(posedge clk) begin
    if ((r_state == S_EMIT) && out_ready) begin
      r_rx[r_wr_ptr] <= r_ai_rx;
      r_qy[r_wr_ptr] <= r_ai_qy;
      r_f[r_wr_ptr]  <= r_best;
    end
  end

  // Datapath: anchor latch, issue registers, counters and best-score fold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_n_stored  <= '0;
      r_seq       <= '0;
      r_cnt       <= '0;
      r_j         <= '0;
      r_ai_rx     <= '0;
      r_ai_qy     <= '0;
      r_ai_w      <= '0;
      r_best      <= '0;
      r_best_pred <= '0;
      r_idx       <= '0;
      r_sc_rix    <= '0;
      r_sc_riy    <= '0;
      r_sc_qix    <= '0;
      r_sc_qiy    <= '0;
      r_sc_w      <= '0;
      r_sc_wavg   <= '0;
      r_cur_ok    <= 1'b0;
      r_cur_j     <= '0;
      r_cur_f     <= '0;
    end else begin
      if (w_take) begin
        r_best      <= w_cand;
        r_best_pred <= w_exit.j;
      end
      if (w_accept) begin
        r_ai_rx     <= in_rx;
        r_ai_qy     <= in_qy;
        r_ai_w      <= in_w;
        r_best      <= in_w;
        r_best_pred <= '1;
        r_idx       <= r_seq;
      end else if ((r_state == S_IDLE) && chain_clear) begin
        r_n_stored <= '0;
        r_seq      <= '0;
        r_wr_ptr   <= '0;
      end
      if (w_load_first)               r_cnt <= r_n_stored;
      else if (r_state == S_ISSUE)    r_cnt <= r_cnt - 32'd1;
      if (w_load) begin
        r_sc_rix  <= w_a_rx;
        r_sc_riy  <= r_rx[w_rd_addr];
        r_sc_qix  <= w_a_qy;
        r_sc_qiy  <= r_qy[w_rd_addr];
        r_sc_w    <= w_a_w;
        r_sc_wavg <= cfg_w_avg;
        r_cur_ok  <= w_ok;
        r_cur_j   <= w_jsel;
        r_cur_f   <= r_f[w_rd_addr];
        r_j       <= w_jsel;
      end
      if ((r_state == S_EMIT) && out_ready) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_seq    <= r_seq + 32'd1;
        if (r_n_stored != 32'(DEPTH - 1)) r_n_stored <= r_n_stored + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_chain_pred_issuer.sv
// Directed bench for chain_pred_issuer with a pipelined score-unit stub and a
// reference chaining model feeding an expected-result queue.
module tb_chain_pred_issuer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LAT   = 6;

  logic        clk = 1'b0;
  logic        reset, chain_clear, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_rx, in_qy, in_w, cfg_w_avg, sc_result;
  logic [31:0] sc_riX, sc_riY, sc_qiX, sc_qiY, sc_W, sc_W_avg;
  logic [31:0] out_score, out_pred, out_idx;

  chain_pred_issuer #(.DEPTH(DEPTH), .SCORE_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .chain_clear(chain_clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rx(in_rx), .in_qy(in_qy), .in_w(in_w), .cfg_w_avg(cfg_w_avg),
    .sc_riX(sc_riX), .sc_riY(sc_riY), .sc_qiX(sc_qiX), .sc_qiY(sc_qiY),
    .sc_W(sc_W), .sc_W_avg(sc_W_avg), .sc_result(sc_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_score(out_score), .out_pred(out_pred), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] score;
    logic [31:0] pred;
    logic [31:0] idx;
    int          lat;
  } exp_t;
  exp_t sb[$];

  logic [31:0] m_rx[$];
  logic [31:0] m_qy[$];
  logic [31:0] m_f[$];

  int          stub_mode = 0;   // 0: constant stub_k, 1: reference gap riX-riY
  logic [31:0] stub_k = 32'd10;
  logic [31:0] stub_pipe [LAT];

  function automatic logic [31:0] stub_fn(input logic [31:0] a_rx, input logic [31:0] p_rx);
    if (stub_mode == 1) return a_rx - p_rx;
    return stub_k;
  endfunction

  // Score-unit stub: LAT-stage pipeline, result for inputs seen in cycle t shows in t+LAT.
  always @(posedge clk) begin
    stub_pipe[0] <= stub_fn(sc_riX, sc_riY);
    for (int k = 1; k < int'(LAT); k++) stub_pipe[k] <= stub_pipe[k-1];
  end
  assign sc_result = stub_pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_rx.delete(); m_qy.delete(); m_f.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic do_clear();
    @(negedge clk);
    chain_clear = 1'b1;
    @(negedge clk);
    chain_clear = 1'b0;
    model_clear();
  endtask

  // Drive one anchor, check issue window, latency, hold behaviour and result.
  task automatic do_anchor(input logic [31:0] rx, input logic [31:0] qy,
                           input logic [31:0] w, input int hold);
    exp_t e;
    int   s, n, b, cyc;
    logic [31:0] cand;
    s = m_rx.size();
    n = (s < int'(DEPTH) - 1) ? s : int'(DEPTH) - 1;
    e.score = w; e.pred = '1; e.idx = 32'(s);
    e.lat = (n > 0) ? n + int'(LAT) + 1 : 1;
    for (int d = 1; d <= n; d++) begin
      cand = m_f[s-d] + stub_fn(rx, m_rx[s-d]);
      if ((m_rx[s-d] < rx) && (m_qy[s-d] < qy) && ($signed(cand) > $signed(e.score))) begin
        e.score = cand;
        e.pred  = 32'(s - d);
      end
    end
    b = 0;
    while (!in_ready && b < 50) begin @(negedge clk); b++; end
    if (!in_ready) begin
      chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
      return;
    end
    sb.push_back(e);
    in_valid = 1'b1; in_rx = rx; in_qy = qy; in_w = w;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
    while (!out_valid && cyc < n + int'(LAT) + 30) begin
      if (n > 0 && cyc == 1) begin
        chk("sc_riX", sc_riX, rx);
        chk("sc_qiX", sc_qiX, qy);
        chk("sc_W", sc_W, w);
        chk("sc_W_avg", sc_W_avg, cfg_w_avg);
        chk("sc_riY_near", sc_riY, m_rx[s-1]);
        chk("sc_qiY_near", sc_qiY, m_qy[s-1]);
      end
      if (n > 0 && cyc == n) chk("sc_riY_oldest", sc_riY, m_rx[s-n]);
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(e.lat));
    e = sb.pop_front();
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_score", out_score, e.score);
      chk("hold_pred", out_pred, e.pred);
      chk("hold_idx", out_idx, e.idx);
      @(negedge clk);
    end
    chk("out_score", out_score, e.score);
    chk("out_pred", out_pred, e.pred);
    chk("out_idx", out_idx, e.idx);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_in_ready", {31'd0, in_ready}, 32'd1);
    m_rx.push_back(rx); m_qy.push_back(qy); m_f.push_back(e.score);
  endtask

  // Accept an anchor, then reset while its results are still in flight.
  task automatic reset_in_drain(input logic [31:0] rx, input logic [31:0] qy, input logic [31:0] w);
    int n;
    n = (m_rx.size() < int'(DEPTH) - 1) ? m_rx.size() : int'(DEPTH) - 1;
    in_valid = 1'b1; in_rx = rx; in_qy = qy; in_w = w;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n + 2) @(negedge clk);
    chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_sc_riX", sc_riX, 32'd0);
    model_clear();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; chain_clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_rx = '0; in_qy = '0; in_w = '0; cfg_w_avg = 32'd77;
    do_reset();

    // reset values
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_score", out_score, 32'd0);
    chk("rst_out_pred", out_pred, 32'd0);
    chk("rst_out_idx", out_idx, 32'd0);
    chk("rst_sc_riX", sc_riX, 32'd0);
    chk("rst_sc_riY", sc_riY, 32'd0);
    chk("rst_sc_qiX", sc_qiX, 32'd0);
    chk("rst_sc_qiY", sc_qiY, 32'd0);
    chk("rst_sc_W", sc_W, 32'd0);
    chk("rst_sc_W_avg", sc_W_avg, 32'd0);

    // first anchor with empty window, then one colinear predecessor
    stub_mode = 0; stub_k = 32'd10;
    do_anchor(32'd100, 32'd50, 32'd15, 0);
    do_anchor(32'd120, 32'd70, 32'd15, 0);

    // non-colinear predecessor is issued but ignored
    do_reset();
    do_anchor(32'd100, 32'd50, 32'd15, 0);
    do_anchor(32'd90,  32'd70, 32'd15, 0);

    // tie between two predecessors keeps the nearer one
    do_clear();
    stub_mode = 1;
    do_anchor(32'd100, 32'd50, 32'd15, 0);
    do_anchor(32'd120, 32'd70, 32'd15, 0);
    do_anchor(32'd140, 32'd90, 32'd15, 0);

    // negative scores never beat the anchor span
    do_clear();
    stub_mode = 0; stub_k = 32'hFFFF_FF9C;
    do_anchor(32'd100, 32'd50, 32'd15, 0);
    do_anchor(32'd120, 32'd70, 32'd15, 0);
    do_anchor(32'd140, 32'd90, 32'd15, 0);

    // window wrap with a saturated predecessor count
    do_clear();
    stub_k = 32'd3;
    for (int k = 0; k < int'(DEPTH) + 5; k++)
      do_anchor(32'(100 + 10 * k), 32'(50 + 10 * k), 32'd15, 0);

    // back-pressure hold, then reset in the middle of a drain
    do_anchor(32'd1000, 32'd1000, 32'd15, 5);
    stub_k = 32'd1000;
    reset_in_drain(32'd1010, 32'd1010, 32'd15);
    do_anchor(32'd5, 32'd5, 32'd7, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/chain_pred_issuer.md
# chain_pred_issuer

Anchor-chaining front end that drives and drains the pipelined pair-score unit. It accepts one anchor at a time and stores it in a predecessor window. For each accepted anchor it issues one (anchor, predecessor) pair per cycle to the score unit and tracks each in-flight pair with a tag delay line matched to the score latency. It then folds the returned scores into the best chain score f(i) and best predecessor, and emits them on a ready/valid output.

## Interface
Parameters:
- DEPTH, 64 — ring size. Power of two. At most DEPTH-1 predecessors are examined per anchor.
- SCORE_LAT, 12 — cycles from sc_* inputs to the matching sc_result of the score unit. Must equal the instantiated unit's latency.

Ports:
- clk  in  1  — single clock.
- reset  in  1  — synchronous, active-high.
- chain_clear  in  1  — empties the window and zeroes the anchor counter. Honoured only in IDLE.
- in_valid  in  1 / in_ready  out  1  — anchor input handshake.
- in_rx  in  32  — anchor reference position (unsigned).
- in_qy  in  32  — anchor query position (unsigned).
- in_w  in  32  — anchor span (unsigned).
- cfg_w_avg  in  32  — passed unchanged to sc_W_avg.
- sc_riX, sc_riY  out  32  — reference position of anchor i and of predecessor j.
- sc_qiX, sc_qiY  out  32  — query position of anchor i and of predecessor j.
- sc_W  out  32  — span of anchor i.
- sc_W_avg  out  32  — cfg_w_avg.
- sc_result  in  32  — signed pair score, SCORE_LAT cycles after issue.
- out_valid  in/out  — out_valid  out  1 / out_ready  in  1  — result handshake.
- out_score  out  32  — signed f(i).
- out_pred  out  32  — sequence index of the best predecessor, or 32'hFFFFFFFF if none.
- out_idx  out  32  — sequence index of anchor i, counted from the last reset or clear.

## Operation
- Storage: ring arrays rx, qy, f (32 b each) addressed by wr_ptr. n_stored saturates at DEPTH-1. seq counts accepted anchors.
- States:
  - IDLE: in_ready=1. On accept, latch the anchor, set cnt=n_stored and j=seq-1, best=in_w, best_pred=32'hFFFFFFFF. Go to ISSUE if cnt>0, else EMIT. If chain_clear=1 in IDLE with no accept, zero n_stored, seq and wr_ptr. Accept has priority when both are present.
  - ISSUE: each cycle, drive sc_* from anchor i and ring entry j (registered outputs). Push tag {valid, j, f(j)} into the SCORE_LAT-deep delay line. tag.valid = (rx_j < rx_i) && (qy_j < qy_i), strictly. Decrement j and cnt. After the cnt-th issue, go to DRAIN.
  - DRAIN: wait until the delay line holds no tags, then go to EMIT.
  - EMIT: out_valid=1 with best and best_pred. On out_ready: write f[wr_ptr]=best, increment wr_ptr (mod DEPTH), seq, and n_stored (saturating), then go to IDLE.
- Fold: this happens every cycle a tag exits the delay line, in any state.
  - cand = tag.f + sc_result, as signed 32-bit two's complement with wrap and no saturation.
  - If tag.valid and cand > best (signed, strict), then best=cand and best_pred=tag.j.
  - Predecessors are issued nearest-first, so ties keep the nearer predecessor.
- in_ready=0 in every state except IDLE.
- sc_* hold their last value when not issuing.
- Reset at any point: return to IDLE, clear the delay line (in-flight results are discarded), zero n_stored, seq and wr_ptr. Ring data contents are don't-care.

## Timing
- Reset values: in_ready=1 (decoded from IDLE), out_valid=0, out_score=0, out_pred=0, out_idx=0, all sc_*=0.
- Accept at cycle T, cnt>0:
  - Pairs are issued in cycles T+1 … T+cnt, one per cycle, with no bubbles.
  - The result for the pair issued at t is folded at t+SCORE_LAT.
  - out_valid first rises at T+cnt+SCORE_LAT+1.
- Accept at cycle T, cnt=0: out_valid rises at T+1.
- While out_valid=1 and out_ready=0, all out_* are held stable.
- The earliest next accept is the cycle after the out handshake.
- Throughput: one anchor per cnt+SCORE_LAT+2 cycles.

## Test plan
1. Reset, then anchor (rx=100, qy=50, w=15) at T -> out_valid at T+1, out_score=15, out_pred=FFFFFFFF, out_idx=0; no sc issue cycles.
2. Score stub returns constant 10. Send anchor (100,50,15) and consume it, then send (120,70,15) at T -> exactly one issue (sc_riX=120, sc_riY=100, sc_qiX=70, sc_qiY=50). out_valid at T+SCORE_LAT+2, out_score=25, out_pred=0, out_idx=1.
3. Non-colinear predecessor: (100,50,15) followed by (90,70,15), stub returns 10 -> the pair is issued but ignored; out_score=15, out_pred=FFFFFFFF.
4. Tie and negative scores: anchors 0,1 both colinear with anchor 2. Stub returns scores making both candidates 40 -> out_pred=1. Stub returning -100 for both -> out_score=in_w, out_pred=FFFFFFFF.
5. Window wrap: stream DEPTH+5 colinear anchors -> anchor k issues min(k, DEPTH-1) pairs. For k≥DEPTH, the oldest predecessor issued is k-DEPTH+1, and the ring read addresses wrap correctly.
6. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0. Then assert reset during DRAIN of a later anchor -> out_valid=0 the next cycle, late sc_result values are ignored, and the next anchor gets out_idx=0 with no issues.
